// File: rtl/instr_issue.sv
// Instruction fetch/issue front end: reads a program from synchronous instruction memory,
// drops illegal opcodes, buffers words in a prefetch FIFO and issues them over valid/ready.
module instr_issue #(
   parameter int unsigned PC_W  = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic            clk,
   input  logic            sys_rst,
   input  logic            start,
   input  logic [PC_W-1:0] start_pc,
   input  logic [PC_W:0]   prog_len,
   input  logic            halt_req,
   output logic            imem_rd,
   output logic [PC_W-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     ir,
   output logic            ir_valid,
   input  logic            ir_ready,
   output logic [PC_W-1:0] pc_out,
   output logic            busy,
   output logic            done,
   output logic            illegal
);

   localparam int unsigned PtrW  = $clog2(DEPTH);
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned OccW  = CntW + 1;
   localparam logic [4:0]  MaxOp = 5'd4;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [PC_W:0]     len_q, len_d;
   logic [PC_W:0]     fetched_q, fetched_d;
   logic              inflight_q, inflight_d;
   logic [PC_W-1:0]   infl_addr_q, infl_addr_d;
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [31:0]       ir_q, ir_d;
   logic [PC_W-1:0]   pc_out_q, pc_out_d;
   logic              ir_valid_q, ir_valid_d;
   logic              illegal_q, illegal_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [31:0]       fifo_data_q [DEPTH];
   logic [PC_W-1:0]   fifo_addr_q [DEPTH];

   logic              active;
   logic              halt;
   logic              rd;
   logic              opcode_ok;
   logic              push;
   logic              pop;
   logic [OccW-1:0]   occupancy;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      len_d       = len_q;
      fetched_d   = fetched_q;
      infl_addr_d = infl_addr_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      ir_d        = ir_q;
      pc_out_d    = pc_out_q;
      ir_valid_d  = ir_valid_q;
      illegal_d   = illegal_q;

      active    = (state_q == StRun) || (state_q == StDrain);
      halt      = halt_req && active;
      // Reserve a FIFO slot for the read still returning so a push never finds it full.
      occupancy = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
      rd        = (state_q == StRun) && !halt && (fetched_q < len_q)
                  && (occupancy < OccW'(DEPTH));
      opcode_ok = imem_rdata[31:27] <= MaxOp;
      push      = inflight_q && opcode_ok && !halt;
      pop       = (count_q != '0) && (!ir_valid_q || ir_ready) && !halt;

      inflight_d = rd;
      if (rd) begin
         pc_d        = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
         fetched_d   = fetched_q + {{PC_W{1'b0}}, 1'b1};
         infl_addr_d = pc_q;
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + {{(PtrW-1){1'b0}}, 1'b1};
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + {{(PtrW-1){1'b0}}, 1'b1};
      end
      case ({push, pop})
         2'b10:   count_d = count_q + {{(CntW-1){1'b0}}, 1'b1};
         2'b01:   count_d = count_q - {{(CntW-1){1'b0}}, 1'b1};
         default: count_d = count_q;
      endcase

      if (pop) begin
         ir_d       = fifo_data_q[rd_ptr_q];
         pc_out_d   = fifo_addr_q[rd_ptr_q];
         ir_valid_d = 1'b1;
      end else if (ir_valid_q && ir_ready) begin
         ir_valid_d = 1'b0;
      end

      if (inflight_q && !opcode_ok && !halt) begin
         illegal_d = 1'b1;
      end

      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               pc_d      = start_pc;
               len_d     = prog_len;
               fetched_d = '0;
               illegal_d = 1'b0;
               state_d   = (prog_len == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            if (fetched_q == len_q) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if ((count_q == '0) && !inflight_q && !ir_valid_q) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase

      // Abort wins over everything: drop buffered words and the returning read.
      if (halt) begin
         state_d    = StDone;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         inflight_d = 1'b0;
         ir_valid_d = 1'b0;
         ir_d       = '0;
         pc_out_d   = '0;
      end

      busy_d = (state_d == StRun) || (state_d == StDrain);
      done_d = (state_d == StDone);
   end

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state_q     <= StIdle;
         pc_q        <= '0;
         len_q       <= '0;
         fetched_q   <= '0;
         inflight_q  <= 1'b0;
         infl_addr_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ir_q        <= '0;
         pc_out_q    <= '0;
         ir_valid_q  <= 1'b0;
         illegal_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         len_q       <= len_d;
         fetched_q   <= fetched_d;
         inflight_q  <= inflight_d;
         infl_addr_q <= infl_addr_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ir_q        <= ir_d;
         pc_out_q    <= pc_out_d;
         ir_valid_q  <= ir_valid_d;
         illegal_q   <= illegal_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Storage needs no reset: count_q alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data_q[wr_ptr_q] <= imem_rdata;
         fifo_addr_q[wr_ptr_q] <= infl_addr_q;
      end
   end

   assign imem_rd   = rd;
   assign imem_addr = pc_q;
   assign ir        = ir_q;
   assign ir_valid  = ir_valid_q;
   assign pc_out    = pc_out_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_instr_issue.sv
// Scoreboard bench for instr_issue: directed programs push expected (ir, pc) pairs,
// a forked monitor pops and compares on every ir_valid & ir_ready transfer.
module tb_instr_issue;

   logic        clk = 1'b0;
   logic        sys_rst;
   logic        start;
   logic [7:0]  start_pc;
   logic [8:0]  prog_len;
   logic        halt_req;
   logic        imem_rd;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata = '0;
   logic [31:0] ir;
   logic        ir_valid;
   logic        ir_ready;
   logic [7:0]  pc_out;
   logic        busy;
   logic        done;
   logic        illegal;

   typedef struct packed {
      logic [31:0] ir;
      logic [7:0]  pc;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem [256];
   logic [7:0]  addr_log[$];
   int          rd_cnt = 0;
   int          n_vec = 0;
   int          n_err = 0;

   instr_issue #(.PC_W(8), .DEPTH(4)) dut (
      .clk        (clk),
      .sys_rst    (sys_rst),
      .start      (start),
      .start_pc   (start_pc),
      .prog_len   (prog_len),
      .halt_req   (halt_req),
      .imem_rd    (imem_rd),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .ir         (ir),
      .ir_valid   (ir_valid),
      .ir_ready   (ir_ready),
      .pc_out     (pc_out),
      .busy       (busy),
      .done       (done),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   // Synchronous memory: data valid the cycle after the read strobe.
   always @(posedge clk) begin
      if (imem_rd) begin
         imem_rdata <= mem[imem_addr];
         rd_cnt     <= rd_cnt + 1;
         addr_log.push_back(imem_addr);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] pc, input logic [8:0] len);
      start_pc = pc;
      prog_len = len;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic expect_word(input logic [7:0] a);
      exp_q.push_back({mem[a], a});
   endtask

   task automatic wait_done(input string name, input int bound);
      for (int i = 0; i < bound && !done; i++) tick();
      check(name, {31'b0, done}, 32'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ir"}, ir, 32'h0);
      check({tag, "_ir_valid"}, {31'b0, ir_valid}, 32'h0);
      check({tag, "_pc_out"}, {24'b0, pc_out}, 32'h0);
      check({tag, "_busy"}, {31'b0, busy}, 32'h0);
      check({tag, "_done"}, {31'b0, done}, 32'h0);
      check({tag, "_illegal"}, {31'b0, illegal}, 32'h0);
      check({tag, "_imem_rd"}, {31'b0, imem_rd}, 32'h0);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!sys_rst && ir_valid && ir_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_issue: got ir=%h pc=%h, required no issue", ir, pc_out);
            end else begin
               e = exp_q.pop_front();
               check("issue_ir", ir, e.ir);
               check("issue_pc", {24'b0, pc_out}, {24'b0, e.pc});
            end
         end
      end
   endtask

   initial begin
      int base;
      int lbase;
      logic [7:0] a;

      sys_rst  = 1'b1;
      start    = 1'b0;
      start_pc = '0;
      prog_len = '0;
      halt_req = 1'b0;
      ir_ready = 1'b0;
      fork
         monitor();
      join_none
      tick();
      tick();
      check_idle_outputs("reset");
      sys_rst = 1'b0;
      tick();

      // 1: three words, ready high, 3-cycle start latency
      mem[0] = 32'h1040_0005;
      mem[1] = 32'h1080_0003;
      mem[2] = 32'h10C2_0000;
      for (int i = 0; i < 3; i++) expect_word(8'(i));
      ir_ready = 1'b1;
      do_start(8'h00, 9'd3);
      check("t1_busy", {31'b0, busy}, 32'd1);
      check("t1_lat0", {31'b0, ir_valid}, 32'd0);
      tick();
      tick();
      check("t1_lat2", {31'b0, ir_valid}, 32'd0);
      tick();
      check("t1_lat3", {31'b0, ir_valid}, 32'd1);
      wait_done("t1_done", 40);
      check("t1_drained", 32'(exp_q.size()), 32'd0);
      check("t1_busy_done", {31'b0, busy}, 32'd0);

      // 2: back-pressure fills output register plus FIFO, then releases
      for (int i = 0; i < 8; i++) mem[i] = {5'(i % 5), 27'(32'h00A5_0000 + i)};
      for (int i = 0; i < 8; i++) expect_word(8'(i));
      ir_ready = 1'b0;
      base = rd_cnt;
      do_start(8'h00, 9'd8);
      repeat (20) tick();
      check("t2_fetched", 32'(rd_cnt - base), 32'd5);
      check("t2_rd_low", {31'b0, imem_rd}, 32'd0);
      check("t2_ir_hold", ir, mem[0]);
      check("t2_pc_hold", {24'b0, pc_out}, 32'd0);
      ir_ready = 1'b1;
      wait_done("t2_done", 60);
      check("t2_drained", 32'(exp_q.size()), 32'd0);
      check("t2_total_reads", 32'(rd_cnt - base), 32'd8);

      // 3: illegal opcode dropped, sticky flag
      mem[0] = 32'h1040_0005;
      mem[1] = 32'h3800_0000;
      mem[2] = 32'h2000_0001;
      expect_word(8'h00);
      expect_word(8'h02);
      do_start(8'h00, 9'd3);
      wait_done("t3_done", 40);
      check("t3_drained", 32'(exp_q.size()), 32'd0);
      check("t3_illegal", {31'b0, illegal}, 32'd1);
      repeat (3) tick();
      check("t3_illegal_sticky", {31'b0, illegal}, 32'd1);

      // 4: PC wraps from FF to 00
      mem[8'hFE] = 32'h0800_00FE;
      mem[8'hFF] = 32'h1800_00FF;
      mem[8'h00] = 32'h2000_0100;
      mem[8'h01] = 32'h0000_0101;
      expect_word(8'hFE);
      expect_word(8'hFF);
      expect_word(8'h00);
      expect_word(8'h01);
      lbase = addr_log.size();
      do_start(8'hFE, 9'd4);
      check("t4_illegal_cleared", {31'b0, illegal}, 32'd0);
      wait_done("t4_done", 40);
      check("t4_drained", 32'(exp_q.size()), 32'd0);
      check("t4_nreads", 32'(addr_log.size() - lbase), 32'd4);
      for (int i = 0; i < 4; i++) begin
         a = 8'hFE + 8'(i);
         if (lbase + i < addr_log.size())
            check("t4_addr", {24'b0, addr_log[lbase + i]}, {24'b0, a});
      end

      // 5: halt with three buffered words and a read returning
      for (int i = 0; i < 8; i++) mem[8'h10 + 8'(i)] = 32'h0000_0200 + 32'(i);
      ir_ready = 1'b0;
      do_start(8'h10, 9'd8);
      repeat (5) tick();
      check("t5_pre_valid", {31'b0, ir_valid}, 32'd1);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      check("t5_ir_valid", {31'b0, ir_valid}, 32'd0);
      check("t5_ir_clear", ir, 32'h0);
      check("t5_done", {31'b0, done}, 32'd1);
      check("t5_busy", {31'b0, busy}, 32'd0);
      base = rd_cnt;
      ir_ready = 1'b1;
      repeat (10) tick();
      check("t5_no_reads", 32'(rd_cnt - base), 32'd0);
      check("t5_still_done", {31'b0, done}, 32'd1);
      mem[8'h20] = 32'h1111_0000;
      mem[8'h21] = 32'h0222_0000;
      expect_word(8'h20);
      expect_word(8'h21);
      do_start(8'h20, 9'd2);
      wait_done("t5_restart_done", 40);
      check("t5_restart_drained", 32'(exp_q.size()), 32'd0);

      // 6: synchronous reset mid-run, then empty program
      for (int i = 0; i < 8; i++) mem[8'h40 + 8'(i)] = 32'h0000_0300 + 32'(i);
      ir_ready = 1'b0;
      do_start(8'h40, 9'd8);
      repeat (4) tick();
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      check_idle_outputs("t6_rst");
      repeat (3) tick();
      check("t6_stay_idle", {31'b0, ir_valid | busy | done}, 32'd0);
      base = rd_cnt;
      do_start(8'h00, 9'd0);
      check("t6_zero_done", {31'b0, done}, 32'd1);
      check("t6_zero_busy", {31'b0, busy}, 32'd0);
      repeat (3) tick();
      check("t6_zero_reads", 32'(rd_cnt - base), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
